// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode-stage issue control.
// Holds a register scoreboard for RAW/WAW/fence interlocks. A small FSM
// blocks issue while a branch or jump is unresolved, and raises a
// one-cycle flush after a taken redirect.
// Optional feature: define ID_WB_BYPASS_EN so that a source register being
// retired by writeback in the same cycle does not stall.
//
// Handshake: ID presents an instruction with id_valid. It is consumed on a
// cycle where issue_valid=1. id_ready=1 means ID may advance this cycle,
// either because the instruction issues or because ID holds nothing while
// the controller is in RUN. Writeback (wb_valid/wb_addr) and branch
// resolution (ex_resolve/ex_taken) are single-cycle pulses with no
// back-pressure.
module id_issue_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic       rs1_r_ena,
  input  logic [4:0] rs1_r_addr,
  input  logic       rs2_r_ena,
  input  logic [4:0] rs2_r_addr,
  input  logic       rd_w_ena,
  input  logic [4:0] rd_w_addr,
  input  logic       is_bj,
  input  logic       is_fence,
  input  logic       wb_valid,
  input  logic [4:0] wb_addr,
  input  logic       ex_resolve,
  input  logic       ex_taken,
  output logic       id_ready,
  output logic       issue_valid,
  output logic       flush,
  output logic       sb_busy,
  output logic       stall_raw,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] BR_WAIT = 2'd1;
  localparam logic [1:0] FLUSH   = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:1] pending;
  logic [31:1] pending_nxt;
  logic [31:0] pend_ext;
  logic [31:1] set_vec;
  logic [31:1] clr_vec;
  logic        wb_hit_rs1;
  logic        wb_hit_rs2;
  logic        haz_rs1;
  logic        haz_rs2;
  logic        waw;
  logic        fence_block;
  logic        in_run;

  // x0 appears as a constant-zero bit so that lookups of x0 never hazard.
  assign pend_ext = {pending, 1'b0};
  assign in_run   = (state == RUN);

  assign wb_hit_rs1 = wb_valid && (wb_addr == rs1_r_addr);
  assign wb_hit_rs2 = wb_valid && (wb_addr == rs2_r_addr);

  // Source hazards; the writeback match only forgives them in bypass builds.
  always_comb begin
`ifdef ID_WB_BYPASS_EN
    haz_rs1 = rs1_r_ena && pend_ext[rs1_r_addr] && !wb_hit_rs1;
    haz_rs2 = rs2_r_ena && pend_ext[rs2_r_addr] && !wb_hit_rs2;
`else
    haz_rs1 = rs1_r_ena && pend_ext[rs1_r_addr];
    haz_rs2 = rs2_r_ena && pend_ext[rs2_r_addr];
`endif
  end

  assign waw = rd_w_ena && (rd_w_addr != 5'd0) && pend_ext[rd_w_addr]
               && !(wb_valid && (wb_addr == rd_w_addr));
  assign fence_block = is_fence && (pending != '0);

  assign issue_valid = id_valid && in_run && !haz_rs1 && !haz_rs2
                       && !waw && !fence_block;
  assign id_ready    = issue_valid || (!id_valid && in_run);
  assign stall_raw   = id_valid && in_run && (haz_rs1 || haz_rs2);
  assign flush       = (state == FLUSH);
  assign sb_busy     = |pending;
  assign dbg_state   = state;

  // Per-register set and clear strobes. The set is applied last so that it
  // wins over a same-cycle clear of the same register.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 1; i < 32; i++) begin
      set_vec[i] = issue_valid && rd_w_ena && (rd_w_addr == 5'(i));
      clr_vec[i] = wb_valid && (wb_addr == 5'(i));
    end
    pending_nxt = (pending & ~clr_vec) | set_vec;
  end

  // Branch FSM: wait for resolution after a branch/jump issues.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (issue_valid && is_bj) state_nxt = BR_WAIT;
      BR_WAIT: if (ex_resolve) state_nxt = ex_taken ? FLUSH : RUN;
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: table-driven directed bench for id_issue_ctrl, plus
// hand-written sequences for writeback bypass and reset during BR_WAIT.
module tb_id_issue_ctrl;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_BRW   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, is_bj, is_fence;
  logic [4:0] rs1_r_addr, rs2_r_addr, rd_w_addr, wb_addr;
  logic       wb_valid, ex_resolve, ex_taken;
  logic       id_ready, issue_valid, flush, sb_busy, stall_raw;
  logic [1:0] dbg_state;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .is_bj(is_bj), .is_fence(is_fence),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .id_ready(id_ready), .issue_valid(issue_valid), .flush(flush),
    .sb_busy(sb_busy), .stall_raw(stall_raw), .dbg_state(dbg_state)
  );

  // ---------------- vector record ----------------
  typedef struct packed {
    logic       idv;
    logic       r1e;
    logic [4:0] r1a;
    logic       r2e;
    logic [4:0] r2a;
    logic       rde;
    logic [4:0] rda;
    logic       bj;
    logic       fe;
    logic       wbv;
    logic [4:0] wba;
    logic       exr;
    logic       ext;
    logic [4:0] exp_o;   // {id_ready, issue_valid, flush, sb_busy, stall_raw}
    logic [1:0] exp_st;
  } vec_t;

  function automatic vec_t mk(
    input logic idv, input logic r1e, input logic [4:0] r1a,
    input logic r2e, input logic [4:0] r2a,
    input logic rde, input logic [4:0] rda,
    input logic bj, input logic fe,
    input logic wbv, input logic [4:0] wba,
    input logic exr, input logic ext,
    input logic [4:0] exp_o, input logic [1:0] exp_st);
    vec_t v;
    v.idv = idv; v.r1e = r1e; v.r1a = r1a; v.r2e = r2e; v.r2a = r2a;
    v.rde = rde; v.rda = rda; v.bj = bj; v.fe = fe;
    v.wbv = wbv; v.wba = wba; v.exr = exr; v.ext = ext;
    v.exp_o = exp_o; v.exp_st = exp_st;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp_o, input logic [1:0] exp_st);
    chk({tag, ".id_ready"},    32'(id_ready),    32'(exp_o[4]));
    chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(exp_o[3]));
    chk({tag, ".flush"},       32'(flush),       32'(exp_o[2]));
    chk({tag, ".sb_busy"},     32'(sb_busy),     32'(exp_o[1]));
    chk({tag, ".stall_raw"},   32'(stall_raw),   32'(exp_o[0]));
    chk({tag, ".state"},       32'(dbg_state),   32'(exp_st));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t v);
    id_valid = v.idv; rs1_r_ena = v.r1e; rs1_r_addr = v.r1a;
    rs2_r_ena = v.r2e; rs2_r_addr = v.r2a;
    rd_w_ena = v.rde; rd_w_addr = v.rda;
    is_bj = v.bj; is_fence = v.fe;
    wb_valid = v.wbv; wb_addr = v.wba;
    ex_resolve = v.exr; ex_taken = v.ext;
  endtask

  task automatic idle();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,5'b0,S_RUN));
  endtask

  // Drive a vector just after a rising edge, then check mid-cycle.
  task automatic step(input string tag, input vec_t v);
    @(posedge clk); #1;
    drive(v);
    #3;
    chk_outs(tag, v.exp_o, v.exp_st);
  endtask

  vec_t vecs[21];

  initial begin
    // Expected output bits: {id_ready, issue_valid, flush, sb_busy, stall_raw}
    //           idv r1e r1a r2e r2a rde rda bj fe wbv wba exr ext  exp      st
    vecs[0]  = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 5'b10000, S_RUN);   // idle
    vecs[1]  = mk(1, 1, 0,  0, 0,  1, 5,  0, 0, 0, 0,  0, 0, 5'b11000, S_RUN);   // addi x5
    vecs[2]  = mk(1, 1, 5,  0, 0,  1, 6,  0, 0, 0, 0,  0, 0, 5'b00011, S_RUN);   // rs1=x5 RAW
    vecs[3]  = mk(1, 0, 0,  1, 5,  0, 0,  0, 0, 1, 9,  0, 0, 5'b00011, S_RUN);   // rs2=x5 RAW, wb x9 idle clear
    vecs[4]  = mk(1, 1, 0,  1, 0,  1, 0,  0, 0, 0, 0,  0, 0, 5'b11010, S_RUN);   // x0 sources, rd x0
    vecs[5]  = mk(1, 0, 5,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 5'b11010, S_RUN);   // rs1 disabled
    vecs[6]  = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 1, 5,  0, 0, 5'b10010, S_RUN);   // wb x5
    vecs[7]  = mk(1, 1, 5,  0, 0,  1, 7,  0, 0, 0, 0,  0, 0, 5'b11000, S_RUN);   // x5 free, set x7
    vecs[8]  = mk(1, 0, 0,  0, 0,  1, 7,  0, 0, 1, 7,  0, 0, 5'b11010, S_RUN);   // WAW x7 with wb x7
    vecs[9]  = mk(1, 0, 0,  0, 0,  1, 7,  0, 0, 0, 0,  0, 0, 5'b00010, S_RUN);   // WAW: x7 still pending
    vecs[10] = mk(1, 0, 0,  0, 0,  0, 0,  0, 1, 1, 7,  0, 0, 5'b00010, S_RUN);   // fence blocked
    vecs[11] = mk(1, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0,  0, 0, 5'b11000, S_RUN);   // fence issues
    vecs[12] = mk(1, 0, 0,  0, 0,  1, 1,  1, 0, 0, 0,  0, 0, 5'b11000, S_RUN);   // jal x1
    vecs[13] = mk(1, 1, 1,  0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 5'b00010, S_BRW);   // BR_WAIT, wb x1
    vecs[14] = mk(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  1, 1, 5'b00000, S_BRW);   // resolve taken
    vecs[15] = mk(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  1, 1, 5'b00100, S_FLUSH); // flush, resolve ignored
    vecs[16] = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 5'b10000, S_RUN);   // back in RUN
    vecs[17] = mk(1, 0, 0,  0, 0,  0, 0,  1, 0, 0, 0,  0, 0, 5'b11000, S_RUN);   // beq
    vecs[18] = mk(1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  1, 0, 5'b00000, S_BRW);   // resolve not taken
    vecs[19] = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  1, 1, 5'b10000, S_RUN);   // stray resolve in RUN
    vecs[20] = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 5'b10000, S_RUN);   // still RUN, no flush

    // Reset state check while rst_n is low.
    idle();
    #12;
    chk_outs("reset", 5'b10000, S_RUN);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Writeback bypass of a source register retiring this cycle.
    step("byp.set_x5", mk(1,0,0,0,0,1,5,0,0,0,0,0,0,5'b11000,S_RUN));
`ifdef ID_WB_BYPASS_EN
    step("byp.same_cycle", mk(1,1,5,0,0,1,6,0,0,1,5,0,0,5'b11010,S_RUN));
    step("byp.clear_x6", mk(0,0,0,0,0,0,0,0,0,1,6,0,0,5'b10010,S_RUN));
`else
    step("byp.same_cycle", mk(1,1,5,0,0,1,6,0,0,1,5,0,0,5'b00011,S_RUN));
    step("byp.next_cycle", mk(1,1,5,0,0,1,6,0,0,0,0,0,0,5'b11000,S_RUN));
    step("byp.clear_x6", mk(0,0,0,0,0,0,0,0,0,1,6,0,0,5'b10010,S_RUN));
`endif
    step("byp.empty", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,5'b10000,S_RUN));

    // Reset asserted in the middle of BR_WAIT.
    step("rst.jal_x2", mk(1,0,0,0,0,1,2,1,0,0,0,0,0,5'b11000,S_RUN));
    step("rst.br_wait", mk(1,0,0,0,0,0,0,0,0,0,0,0,0,5'b00010,S_BRW));
    rst_n = 1'b0;
    #1;
    chk_outs("rst.async", 5'b11000, S_RUN);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst.after", mk(0,0,0,0,0,0,0,0,0,0,0,0,0,5'b10000,S_RUN));
    step("rst.after2", mk(1,1,2,0,0,0,0,0,0,0,0,0,0,5'b11000,S_RUN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk in 1 (all state on rising edge); rst_n in 1 (async assert, low = reset).
REQ-002 The block SHALL provide these decode-side inputs: id_valid in 1 (decoded instruction present); rs1_r_ena in 1; rs1_r_addr in 5; rs2_r_ena in 1; rs2_r_addr in 5; rd_w_ena in 1; rd_w_addr in 5.
REQ-003 The block SHALL provide these class inputs: is_bj in 1 (any branch/jal/jalr); is_fence in 1 (fence or fence.i).
REQ-004 The block SHALL provide these writeback inputs: wb_valid in 1; wb_addr in 5 (register retired this cycle).
REQ-005 The block SHALL provide these execute inputs: ex_resolve in 1 (branch/jump outcome valid, one-cycle pulse); ex_taken in 1 (redirect required, qualified by ex_resolve).
REQ-006 The block SHALL provide these outputs: id_ready out 1 (ID may advance); issue_valid out 1 (instruction issued this cycle); flush out 1 (discard ID/IF contents); sb_busy out 1 (any register pending); stall_raw out 1 (source hazard this cycle).

Function
REQ-007 The block SHALL hold a 31-bit scoreboard, pending[31:1], with x0 never pending and reads of x0 never hazarding.
REQ-008 The block SHALL define a hazard on rsN (N = 1, 2) as rsN_r_ena & pending[rsN_r_addr], unless bypassed per REQ-021.
REQ-009 The block SHALL define WAW as rd_w_ena & rd_w_addr!=0 & pending[rd_w_addr] & ~(wb_valid & wb_addr==rd_w_addr).
REQ-010 The block SHALL evaluate fence_block = is_fence & (pending != 0); fence waits for an empty scoreboard.
REQ-011 The block SHALL compute issue_valid = id_valid & state==RUN & no RS hazard & ~WAW & ~fence_block, combinationally.
REQ-012 The block SHALL drive id_ready = issue_valid | (~id_valid & state==RUN).
REQ-013 The block SHALL drive stall_raw = id_valid & state==RUN & (rs1 or rs2 hazard).
REQ-014 On issue_valid with rd_w_ena & rd_w_addr!=0, the block SHALL set pending[rd_w_addr] at the next edge.
REQ-015 On wb_valid with wb_addr!=0, the block SHALL clear pending[wb_addr] at the next edge.
REQ-016 When the set and the clear hit the same address in the same cycle, the set SHALL win (pending stays 1).
REQ-017 A clear of a non-pending register SHALL have no effect; wb_valid SHALL be honoured in every state, including FLUSH.
REQ-018 The FSM SHALL have states RUN, BR_WAIT and FLUSH: RUN -> BR_WAIT on issue_valid & is_bj; BR_WAIT -> FLUSH on ex_resolve & ex_taken; BR_WAIT -> RUN on ex_resolve & ~ex_taken; FLUSH -> RUN unconditionally after one cycle.
REQ-019 The block SHALL assert flush=1 only in FLUSH, with id_ready=0 and issue_valid=0 in that cycle; in BR_WAIT, id_ready=0.
REQ-020 ex_resolve in RUN or FLUSH SHALL be ignored; sb_busy SHALL be the OR of pending[31:1], registered state only.

Reset
REQ-022 While rst_n=0, the block SHALL hold pending=0 and state=RUN, so flush=0 and sb_busy=0, with issue_valid and id_ready following REQ-011/REQ-012 from the reset state.
REQ-023 Deassertion of rst_n SHALL take effect at the next clk edge; reset mid-BR_WAIT SHALL return to RUN without asserting flush.

Configuration
REQ-021 With ID_WB_BYPASS_EN defined, a source whose register matches wb_valid & wb_addr in the same cycle SHALL NOT hazard; without it, that source stalls until the cycle after the clear.

Verification
REQ-024 Bypass: issue addi x5 (pending[5]=1), then id rs1=x5 with wb_valid, wb_addr=5 in the same cycle -> with ID_WB_BYPASS_EN issue_valid=1 that cycle; without it stall_raw=1, issue_valid=1 one cycle later.
REQ-025 WAW with same-cycle set/clear: pending[7]=1, id rd=x7 with wb_addr=7 -> issue_valid=1 and pending[7]=1 after the edge.
REQ-026 Taken branch: issue with is_bj=1 -> id_ready=0 in BR_WAIT; ex_resolve=1, ex_taken=1 -> flush=1 for exactly one cycle, then RUN with id_ready=1.
REQ-027 Not-taken branch: ex_resolve=1, ex_taken=0 -> RUN on the next cycle with flush never asserted; a stray ex_resolve in RUN leaves the state unchanged.
REQ-028 Fence: pending[3]=1, id is_fence=1 -> issue_valid=0 until wb_addr=3 retires, then issue_valid=1 the next cycle.
REQ-029 x0 and reset: rd=x0 issue leaves pending=0; rst_n low during BR_WAIT -> state RUN, flush=0, sb_busy=0 immediately.
